// File: rtl/pdua_int_ctrl.sv
// Prioritised interrupt controller feeding the PDUA control unit INT input.
// Latency: irq edge -> pending in 3 cycles, pending -> INT pulse in 1 more cycle.
// Backpressure: one dispatch in flight; new requests queue in pending until eoi.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   irq          asynchronous level request lines (active high)
//   mask_we      load strobe for mask_wdata into the enable mask
//   gie          global interrupt enable
//   int_ack      acknowledge from the control unit's int_clr
//   eoi          end-of-interrupt (handler returned)
//   INT          single-cycle registered request pulse
//   int_vec      vector of the dispatched source (VEC_BASE + id)
//   int_id       index of the dispatched source
//   in_service   high from acknowledge until eoi
//   pending      pending request status
//   mask         current enable mask
module pdua_int_ctrl #(
  parameter int N_SRC       = 4,
  parameter int VEC_W       = 8,
  parameter int VEC_BASE    = 8'h80,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             gie,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             INT,
  output logic [VEC_W-1:0] int_vec,
  output logic [2:0]       int_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  // Counter wide enough to hold ACK_TIMEOUT - 1; at least one bit.
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2,
    SERVICE  = 2'd3
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] clr;
  logic [CNT_W-1:0] to_cnt;
  logic [2:0]       sel_id;
  logic             sel_vld;
  logic             ack_take;

  assign rise     = sync2 & ~prev;
  assign cand     = pending & mask & {N_SRC{gie}};
  assign ack_take = (state == WAIT_ACK) && int_ack;

  // Fixed priority: scanning from the top down leaves the lowest set index.
  always_comb begin
    sel_id  = 3'd0;
    sel_vld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_vld = 1'b1;
        sel_id  = 3'(i);
      end
    end
  end

  // Only the acknowledged source is cleared from pending.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = ack_take && (int_id == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      pending    <= '0;
      mask       <= '0;
      int_vec    <= '0;
      int_id     <= '0;
      INT        <= 1'b0;
      in_service <= 1'b0;
      to_cnt     <= '0;
      state      <= IDLE;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync2;

      // A new edge landing on the ack cycle must not be lost: set wins.
      pending <= (pending & ~clr) | rise;

      if (mask_we) begin
        mask <= mask_wdata;
      end

      case (state)
        IDLE: begin
          INT <= 1'b0;
          if (sel_vld) begin
            int_id  <= sel_id;
            int_vec <= VEC_W'(VEC_BASE + int'(sel_id));
            INT     <= 1'b1;
            state   <= REQ;
          end
        end

        REQ: begin
          INT    <= 1'b0;
          to_cnt <= '0;
          state  <= WAIT_ACK;
        end

        WAIT_ACK: begin
          INT <= 1'b0;
          if (int_ack) begin
            in_service <= 1'b1;
            state      <= SERVICE;
          end else if ((ACK_TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
            // Re-issue with the same id/vector; the REQ cycle drives INT.
            INT   <= 1'b1;
            state <= REQ;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        SERVICE: begin
          INT <= 1'b0;
          if (eoi) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          INT   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdua_int_ctrl.sv
module tb_pdua_int_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       gie;
  logic       int_ack;
  logic       eoi;
  logic       INT;
  logic [7:0] int_vec;
  logic [2:0] int_id;
  logic       in_service;
  logic [3:0] pending;
  logic [3:0] mask;

  int checks = 0;
  int errors = 0;

  pdua_int_ctrl #(
    .N_SRC(4), .VEC_W(8), .VEC_BASE(8'h80), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .gie(gie), .int_ack(int_ack), .eoi(eoi), .INT(INT), .int_vec(int_vec),
    .int_id(int_id), .in_service(in_service), .pending(pending), .mask(mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mask(input logic [3:0] v);
    mask_we = 1'b1; mask_wdata = v;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0;
    gie = 1'b0; int_ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL reset_int got %b want 0", INT); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b want 0000", pending); end
    checks++; if (mask !== 4'b0000) begin errors++; $display("FAIL reset_mask got %b want 0000", mask); end
    checks++; if (int_vec !== 8'h00) begin errors++; $display("FAIL reset_vec got %h want 00", int_vec); end
    checks++; if (int_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d want 0", int_id); end
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL reset_insvc got %b want 0", in_service); end
  endtask

  task automatic test_single();
    gie = 1'b1;
    set_mask(4'b1111);
    irq = 4'b0100;
    tick(); tick();  // e1, e2
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_pend_e2 got %b want 0000", pending); end
    tick();          // e3
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pend_e3 got %b want 0100", pending); end
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL single_int_e3 got %b want 0", INT); end
    tick();          // e4
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL single_int_e4 got %b want 1", INT); end
    checks++; if (int_id !== 3'd2) begin errors++; $display("FAIL single_id got %0d want 2", int_id); end
    checks++; if (int_vec !== 8'h82) begin errors++; $display("FAIL single_vec got %h want 82", int_vec); end
    tick();          // e5
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL single_int_e5 got %b want 0", INT); end
    tick();          // e6
    do_ack();        // e7
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_pend_ack got %b want 0000", pending); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL single_insvc_ack got %b want 1", in_service); end
    tick();          // e8
    do_eoi();        // e9
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL single_insvc_eoi got %b want 0", in_service); end
    tick();
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL single_int_idle got %b want 0", INT); end
    irq = '0;
    repeat (3) tick();
  endtask

  task automatic test_priority();
    irq = 4'b1010;
    repeat (3) tick();
    checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL prio_pend got %b want 1010", pending); end
    tick();          // e4
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL prio_int1 got %b want 1", INT); end
    checks++; if (int_id !== 3'd1) begin errors++; $display("FAIL prio_id1 got %0d want 1", int_id); end
    checks++; if (int_vec !== 8'h81) begin errors++; $display("FAIL prio_vec1 got %h want 81", int_vec); end
    tick();          // e5, WAIT_ACK
    // ack and eoi together: the eoi must be dropped
    int_ack = 1'b1; eoi = 1'b1;
    tick();
    int_ack = 1'b0; eoi = 1'b0;
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL prio_pend_ack got %b want 1000", pending); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL prio_insvc_ackeoi got %b want 1", in_service); end
    do_eoi();
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL prio_insvc_eoi got %b want 0", in_service); end
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL prio_int_eoi got %b want 0", INT); end
    tick();          // first edge back in IDLE dispatches source 3
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL prio_int2 got %b want 1", INT); end
    checks++; if (int_id !== 3'd3) begin errors++; $display("FAIL prio_id2 got %0d want 3", int_id); end
    checks++; if (int_vec !== 8'h83) begin errors++; $display("FAIL prio_vec2 got %h want 83", int_vec); end
    tick();
    do_ack();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL prio_pend_end got %b want 0000", pending); end
    do_eoi();
    irq = '0;
    repeat (3) tick();
  endtask

  task automatic test_mask();
    set_mask(4'b1110);
    irq = 4'b0001;
    repeat (3) tick();
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL mask_pend got %b want 0001", pending); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (INT !== 1'b0) begin errors++; $display("FAIL mask_int_masked got %b want 0", INT); end
    end
    set_mask(4'b1111);
    checks++; if (mask !== 4'b1111) begin errors++; $display("FAIL mask_reg got %b want 1111", mask); end
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL mask_int_write got %b want 0", INT); end
    tick();
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL mask_int_unmask got %b want 1", INT); end
    checks++; if (int_id !== 3'd0) begin errors++; $display("FAIL mask_id got %0d want 0", int_id); end
    checks++; if (int_vec !== 8'h80) begin errors++; $display("FAIL mask_vec got %h want 80", int_vec); end
    tick();
    do_ack();
    do_eoi();
    // gie=0 blocks dispatch even with everything unmasked
    gie = 1'b0;
    irq = '0;
    repeat (3) tick();
    irq = 4'b0001;
    repeat (3) tick();
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL gie_pend got %b want 0001", pending); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (INT !== 1'b0) begin errors++; $display("FAIL gie_int_off got %b want 0", INT); end
    end
    gie = 1'b1;
    tick();
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL gie_int_on got %b want 1", INT); end
    tick();
    do_ack();
    do_eoi();
    irq = '0;
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    irq = 4'b0010;
    repeat (4) tick();  // e4
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL to_int1 got %b want 1", INT); end
    checks++; if (int_id !== 3'd1) begin errors++; $display("FAIL to_id1 got %0d want 1", int_id); end
    // e5..e19: no INT; a stray eoi in WAIT_ACK at e10 is ignored
    for (int k = 5; k <= 19; k++) begin
      eoi = (k == 10);
      tick();
      eoi = 1'b0;
      checks++; if (INT !== 1'b0) begin errors++; $display("FAIL to_int_wait e%0d got %b want 0", k, INT); end
    end
    tick();             // e20
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL to_int2 got %b want 1", INT); end
    checks++; if (int_id !== 3'd1) begin errors++; $display("FAIL to_id2 got %0d want 1", int_id); end
    checks++; if (int_vec !== 8'h81) begin errors++; $display("FAIL to_vec2 got %h want 81", int_vec); end
    tick();             // e21
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL to_int_e21 got %b want 0", INT); end
    do_ack();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL to_pend_ack got %b want 0000", pending); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL to_insvc got %b want 1", in_service); end
    do_eoi();
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL to_insvc_eoi got %b want 0", in_service); end
    irq = '0;
    repeat (3) tick();
  endtask

  task automatic test_collision();
    irq = 4'b0100;
    repeat (4) tick();  // e4
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL coll_int1 got %b want 1", INT); end
    irq = '0;
    tick(); tick();     // e5, e6
    irq = 4'b0100;      // sampled at e7, rise seen at e9
    tick(); tick();     // e7, e8
    do_ack();           // e9: set and clear of pending[2] collide
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL coll_pend got %b want 0100", pending); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL coll_insvc got %b want 1", in_service); end
    do_eoi();
    tick();
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL coll_int2 got %b want 1", INT); end
    checks++; if (int_id !== 3'd2) begin errors++; $display("FAIL coll_id2 got %0d want 2", int_id); end
    tick();
    do_ack();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL coll_pend_end got %b want 0000", pending); end
    do_eoi();
    irq = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    irq = 4'b1011;
    repeat (4) tick();  // e4: source 0 dispatched
    checks++; if (int_id !== 3'd0) begin errors++; $display("FAIL rmid_id got %0d want 0", int_id); end
    tick();
    do_ack();
    checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL rmid_pend got %b want 1010", pending); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL rmid_insvc got %b want 1", in_service); end
    rst = 1'b1;
    irq = '0;
    tick();
    rst = 1'b0;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rmid_pend_rst got %b want 0000", pending); end
    checks++; if (mask !== 4'b0000) begin errors++; $display("FAIL rmid_mask_rst got %b want 0000", mask); end
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL rmid_insvc_rst got %b want 0", in_service); end
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL rmid_int_rst got %b want 0", INT); end
    checks++; if (int_vec !== 8'h00) begin errors++; $display("FAIL rmid_vec_rst got %h want 00", int_vec); end
    checks++; if (int_id !== 3'd0) begin errors++; $display("FAIL rmid_id_rst got %0d want 0", int_id); end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (INT !== 1'b0) begin errors++; $display("FAIL rmid_int_quiet got %b want 0", INT); end
    end
    irq = 4'b0001;
    repeat (3) tick();
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL rmid_pend_new got %b want 0001", pending); end
    tick();
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL rmid_int_nomask got %b want 0", INT); end
    set_mask(4'b0001);
    tick();
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL rmid_int_mask got %b want 1", INT); end
    checks++; if (int_vec !== 8'h80) begin errors++; $display("FAIL rmid_vec got %h want 80", int_vec); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_timeout();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdua_int_ctrl.md
Name: pdua_int_ctrl

Overview:
- Prioritised interrupt controller sitting directly upstream of the PDUA control unit. It produces the INT request input that feeds the control unit's interrupt-pending flop.
- Synchronises and edge-detects N_SRC external request lines, holds them as pending, and masks them.
- Dispatches one request at a time as a single-cycle INT pulse plus a vector. It then waits for the control unit's int_clr acknowledge and an end-of-interrupt.

Parameters:
- N_SRC, 4: number of interrupt sources (1..8).
- VEC_W, 8: width of the vector output.
- VEC_BASE, 8'h80: vector of source 0; vector of source i = VEC_BASE + i, truncated to VEC_W bits.
- ACK_TIMEOUT, 15: cycles in WAIT_ACK before INT is re-issued; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- irq  in  N_SRC  asynchronous level request lines, active high.
- mask_we  in  1  write strobe for the enable mask.
- mask_wdata  in  N_SRC  new mask value; 1 = source enabled.
- gie  in  1  global interrupt enable.
- int_ack  in  1  acknowledge pulse, driven from the control unit's int_clr.
- eoi  in  1  end-of-interrupt pulse (handler returned).
- INT  out  1  interrupt request pulse to the control unit.
- int_vec  out  VEC_W  vector of the dispatched source.
- int_id  out  3  index of the dispatched source.
- in_service  out  1  high from acknowledge until eoi.
- pending  out  N_SRC  pending register (status).
- mask  out  N_SRC  current mask register.

Behaviour:
- Reset (rst high at a clock edge):
  - sync flops, edge flops, pending, mask, int_vec, int_id, INT, in_service and the timeout counter all go to 0.
  - State goes to IDLE.
  - Reset overrides every other input, including reset arriving mid-dispatch.
- Input path:
  - 2-flop synchroniser per irq bit, then a previous-value flop.
  - rise[i] = sync2[i] & ~prev[i].
  - Latency: irq first sampled high at edge e1 → sync2 high after e2 → pending[i] set at e3.
- Pending:
  - Set by rise[i].
  - Cleared only when int_ack is accepted for active source i.
  - If set and clear of the same bit occur in the same cycle, set wins (bit stays 1).
  - Masking never clears pending.
- Mask: mask_we loads mask_wdata at the edge; the new value is used from the next cycle.
- Candidate set: cand = pending & mask & {N_SRC{gie}}. Fixed priority, lowest index highest.
- State machine:
  - IDLE: if cand ≠ 0, latch int_id = highest-priority index and int_vec = VEC_BASE + int_id, then go to REQ. For the example above, this is at e4.
  - REQ: INT = 1 for exactly this one cycle. Clear the timeout counter and go to WAIT_ACK.
  - WAIT_ACK:
    - INT = 0.
    - On int_ack: clear pending[int_id], set in_service = 1, go to SERVICE.
    - Otherwise increment the counter. When it reaches ACK_TIMEOUT (if nonzero), go to REQ; int_id and int_vec are unchanged.
  - SERVICE: on eoi, clear in_service and go to IDLE. IDLE may then dispatch on the very next edge.
- Ignored inputs:
  - int_ack outside WAIT_ACK is ignored.
  - eoi outside SERVICE is ignored.
  - int_ack and eoi together in WAIT_ACK: only the ack is taken; eoi is dropped.
- During dispatch:
  - No preemption: higher-priority arrivals during REQ/WAIT_ACK/SERVICE only set pending.
  - Clearing the mask or gie during WAIT_ACK does not abort the dispatch.
- INT is registered (a flop output), never combinational.
- int_vec and int_id hold their values until the next dispatch.

Test Plan:
- Single source: after reset, irq=4'b0100 held high from edge 1 → pending=4'b0100 after edge 3, INT=1 only between edges 4 and 5, int_id=2, int_vec=8'h82. int_ack at edge 7 → pending=0, in_service=1. eoi at edge 9 → in_service=0, state IDLE.
- Priority: irq[3] and irq[1] rise together → first dispatch int_id=1 (vec 8'h81). After ack and eoi, a second INT pulse with int_id=3 (vec 8'h83) appears on the edge after returning to IDLE.
- Masking: mask=4'b1110 and irq[0] rises → pending[0]=1, INT stays 0. Write mask=4'b1111 → INT pulse with int_id=0 two edges after the write. With gie=0, no INT occurs regardless of the mask.
- Timeout: source 1 dispatched, int_ack never asserted, ACK_TIMEOUT=15 → INT re-pulses 16 cycles after the first pulse with the same vector. An ack after the second pulse completes normally.
- Set/clear collision: a new rise of irq[2] lands on the same edge as int_ack for source 2 → pending[2] remains 1, and a second dispatch of source 2 follows the eoi.
- Reset mid-operation: rst asserted in SERVICE with pending=4'b1010 → next cycle all outputs 0, pending=0, mask=0. No INT after rst deasserts until a new irq edge arrives and the mask is written.
